// File: rtl/notch_seq_pkg.sv
// notch_seq_pkg: shared types, default coefficients and widths for the notch biquad sequencer
package notch_seq_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int ACC_W = 2 * WIDTH_DEF + 3;
    localparam int NCOEF = 5;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    typedef enum logic [2:0] {C_B0, C_B1, C_B2, C_A1, C_A2} coef_t;

    localparam logic signed [15:0] DEF_B0 = 16'sd16384;
    localparam logic signed [15:0] DEF_B1 = -16'sd31163;
    localparam logic signed [15:0] DEF_B2 = 16'sd16384;
    localparam logic signed [15:0] DEF_A1 = -16'sd30851;
    localparam logic signed [15:0] DEF_A2 = 16'sd16058;

    function automatic logic signed [15:0] def_coef(input logic [2:0] idx);
        return idx == C_B0 ? DEF_B0 :
               idx == C_B1 ? DEF_B1 :
               idx == C_B2 ? DEF_B2 :
               idx == C_A1 ? DEF_A1 : DEF_A2;
    endfunction
endpackage

// File: rtl/notch_mac.sv
// notch_mac: shared signed multiplier-accumulator with preload, add/sub and operand select
module notch_mac
    import notch_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW = ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          en,
    input  logic                          sub,
    input  logic [2:0]                    sel,
    input  logic signed [AW-1:0]          preload,
    input  logic [NCOEF-1:0][WIDTH-1:0]   coefs,
    input  logic [NCOEF-1:0][WIDTH-1:0]   ops,
    output logic signed [AW-1:0]          acc
);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0] term;

    assign prod = $signed(coefs[sel]) * $signed(ops[sel]);
    assign term = AW'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (load)
            acc <= preload;
        else if (en)
            acc <= sub ? acc - term : acc + term;
    end
endmodule

// File: rtl/notch_biquad_sequencer.sv
// notch_biquad_sequencer: time-multiplexed biquad notch with double-buffered coefficients,
// one shared MAC, rounding, saturation and x/y history.
module notch_biquad_sequencer
    import notch_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC = 14
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic signed [WIDTH-1:0] x_in_i,
    input  logic                    x_valid_i,
    output logic                    x_ready_o,
    output logic signed [WIDTH-1:0] y_out_o,
    output logic                    y_valid_o,
    output logic                    ovf_o,
    input  logic                    cfg_we_i,
    input  logic [2:0]              cfg_addr_i,
    input  logic signed [WIDTH-1:0] cfg_data_i,
    input  logic                    cfg_commit_i,
    output logic                    commit_pend_o,
    input  logic                    flush_i
);
    localparam int AW = 2 * WIDTH + 3;
    localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    state_t state, state_nx;
    logic [2:0] step;
    logic signed [WIDTH-1:0] x_cur, x1, x2, y1, y2, y_sat;
    logic [NCOEF-1:0][WIDTH-1:0] shadow, active;
    logic commit_pend, flush_pend, accept, apply, mac_load, mac_en, y_clip;
    logic signed [AW-1:0] acc, shifted;

    assign commit_pend_o = commit_pend;
    assign shifted = acc >>> FRAC;
    assign y_clip = shifted > SAT_HI || shifted < SAT_LO;
    assign y_sat = shifted > SAT_HI ? SAT_HI[WIDTH-1:0] :
                   shifted < SAT_LO ? SAT_LO[WIDTH-1:0] : shifted[WIDTH-1:0];

    notch_mac #(.WIDTH(WIDTH), .AW(AW)) u_mac (
        .clk(clk_i),
        .rst(reset_i),
        .load(mac_load),
        .en(mac_en),
        .sub(step >= 3'd3),
        .sel(step),
        .preload(RND),
        .coefs(active),
        .ops({y2, y1, x2, x1, x_cur}),
        .acc(acc)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        apply = 1'b0;
        accept = 1'b0;
        mac_load = 1'b0;
        mac_en = 1'b0;
        x_ready_o = 1'b0;
        case (state)
            IDLE: begin
                apply = commit_pend | flush_pend;
                x_ready_o = !apply;
                accept = x_valid_i && !apply;
                mac_load = accept;
                state_nx = accept ? MAC : IDLE;
            end
            MAC: begin
                mac_en = 1'b1;
                state_nx = step == 3'd4 ? DONE : MAC;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step <= '0;
            {x_cur, x1, x2, y1, y2} <= '0;
            y_out_o <= '0;
            y_valid_o <= 1'b0;
            ovf_o <= 1'b0;
            commit_pend <= 1'b0;
            flush_pend <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow[i] <= WIDTH'(def_coef(3'(i)));
                active[i] <= WIDTH'(def_coef(3'(i)));
            end
        end else begin
            y_valid_o <= 1'b0;
            // a request arriving while the previous one is applied stays pending
            commit_pend <= cfg_commit_i | (commit_pend & !apply);
            flush_pend <= flush_i | (flush_pend & !apply);
            if (apply && commit_pend)
                active <= shadow;
            if (cfg_we_i && cfg_addr_i <= C_A2)
                shadow[cfg_addr_i] <= cfg_data_i;
            if (accept) begin
                x_cur <= x_in_i;
                step <= '0;
            end
            if (mac_en)
                step <= step + 3'd1;
            if (apply) begin
                {x1, x2, y1, y2} <= '0;
            end else if (state == DONE) begin
                y_out_o <= y_sat;
                ovf_o <= y_clip;
                y_valid_o <= 1'b1;
                x2 <= x1;
                x1 <= x_cur;
                y2 <= y1;
                y1 <= y_sat;
            end
        end
    end
endmodule

// File: tb/tb_notch_biquad_sequencer.sv
// tb_notch_biquad_sequencer: directed vectors with a queue scoreboard and an independent output monitor
module tb_notch_biquad_sequencer;
    logic clk = 0, reset_i = 1, x_valid = 0, cfg_we = 0, cfg_commit = 0, flush = 0;
    logic [2:0] cfg_addr = 0;
    logic signed [15:0] x_in = 0, cfg_data = 0;
    logic x_ready, y_valid, ovf, commit_pend;
    logic signed [15:0] y_out;

    typedef struct {
        logic signed [15:0] y;
        logic ovf;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int total = 0, bad = 0, cyc = 0;

    notch_biquad_sequencer dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .x_in_i(x_in),
        .x_valid_i(x_valid),
        .x_ready_o(x_ready),
        .y_out_o(y_out),
        .y_valid_o(y_valid),
        .ovf_o(ovf),
        .cfg_we_i(cfg_we),
        .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data),
        .cfg_commit_i(cfg_commit),
        .commit_pend_o(commit_pend),
        .flush_i(flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_i && y_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_y_valid", int'(y_out), 99999);
            end else begin
                m_e = sb.pop_front();
                chk("y", int'(y_out), int'(m_e.y));
                chk("ovf", int'(ovf), int'(m_e.ovf));
                chk("latency", cyc, m_e.cyc);
            end
        end
    end

    // caller sits at a negedge; returns at the negedge after the accepting edge
    task automatic send(input int v, input int ey, input logic eo, input bit hold, input bit push,
                        output int acc);
        int n = 0;
        while (!x_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!x_ready) begin
            bad++;
            $display("FAIL ready_timeout: x_ready got 0 want 1 for x=%0d", v);
            acc = -1;
            return;
        end
        x_in = 16'(v);
        x_valid = 1;
        if (push) sb.push_back('{y: 16'(ey), ovf: eo, cyc: cyc + 7});
        @(negedge clk);
        acc = cyc;
        if (!hold) x_valid = 0;
    endtask

    task automatic write_cfg(input logic [2:0] a, input int d);
        cfg_we = 1;
        cfg_addr = a;
        cfg_data = 16'(d);
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        chk("commit_pend_set", int'(commit_pend), 1);
    endtask

    task automatic wait_pend(output int c);
        int n = 0;
        while (commit_pend && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("commit_pend_clear", int'(commit_pend), 0);
        c = cyc;
    endtask

    task automatic set_bank(input int b0, input int b1, input int b2, input int a1, input int a2);
        int c;
        write_cfg(3'd0, b0);
        write_cfg(3'd1, b1);
        write_cfg(3'd2, b2);
        write_cfg(3'd3, a1);
        write_cfg(3'd4, a2);
        pulse_commit();
        wait_pend(c);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x_ready"}, int'(x_ready), 1);
        chk({tag, "_y_valid"}, int'(y_valid), 0);
        chk({tag, "_y_out"}, int'(y_out), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_commit_pend"}, int'(commit_pend), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, ac, pc;
        bit seen;
        repeat (3) @(negedge clk);
        reset_i = 0;
        check_reset_state("reset");

        // identity: b0 = 1.0
        set_bank(16384, 0, 0, 0, 0);
        send(1000, 1000, 0, 0, 1, ac);
        send(-1000, -1000, 0, 0, 1, ac);

        // one-sample delay through b1
        set_bank(0, 16384, 0, 0, 0);
        send(5, 0, 0, 0, 1, ac);
        send(7, 5, 0, 0, 1, ac);
        send(9, 7, 0, 0, 1, ac);

        // saturation both ways, then an in-range value
        set_bank(32767, 0, 0, 0, 0);
        send(30000, 32767, 1, 0, 1, ac);
        send(-30000, -32768, 1, 0, 1, ac);
        send(10000, 19999, 0, 0, 1, ac);

        // x_valid held high: accepts every 7 cycles
        set_bank(16384, 0, 0, 0, 0);
        send(100, 100, 0, 1, 1, a0);
        send(200, 200, 0, 1, 1, a1);
        send(300, 300, 0, 0, 1, a2);
        chk("spacing_1", a1 - a0, 7);
        chk("spacing_2", a2 - a1, 7);

        // commit issued while 400 is in flight must not touch it
        send(400, 400, 0, 0, 1, ac);
        write_cfg(3'd0, 8192);
        write_cfg(3'd1, 16384);
        pulse_commit();
        wait_pend(pc);
        chk("commit_apply_cycle", pc, ac + 7);
        send(600, 300, 0, 0, 1, ac);
        send(50, 625, 0, 0, 1, ac);

        // reset during MAC step 2 drops the sample and restores defaults
        drain();
        send(1234, 0, 0, 0, 0, ac);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1;
        @(negedge clk);
        @(negedge clk);
        reset_i = 0;
        check_reset_state("midmac");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= y_valid;
        end
        chk("no_pulse_after_reset", int'(seen), 0);

        // default coefficients, golden values
        send(1000, 1000, 0, 0, 1, ac);
        send(0, -19, 0, 0, 1, ac);
        send(0, -16, 0, 0, 1, ac);
        flush = 1;
        @(negedge clk);
        flush = 0;
        send(0, 0, 0, 0, 1, ac);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/notch_biquad_sequencer.md
# notch_biquad_sequencer

Time-multiplexed controller for the second-order IIR notch section. It accepts one input sample per handshake and sequences the five coefficient products through a single shared multiplier-accumulator. It then rounds, saturates and returns the result, and keeps the x/y history. It owns a double-buffered coefficient bank so software can retune the notch without corrupting a sample in flight. It sits between the modulator-side sample source and the DEM/NTF logic downstream.

## Interface
- WIDTH, 16: sample and coefficient width, signed.
- FRAC, 14: coefficient fractional bits (Q2.14 at default WIDTH).
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- x_in_i  in  WIDTH  input sample, signed
- x_valid_i  in  1  input sample valid
- x_ready_o  out  1  sequencer can accept a sample
- y_out_o  out  WIDTH  filtered sample, signed, saturated
- y_valid_o  out  1  one-cycle pulse, y_out_o valid
- ovf_o  out  1  saturation occurred on this y_out_o; qualified by y_valid_o
- cfg_we_i  in  1  write shadow coefficient
- cfg_addr_i  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored
- cfg_data_i  in  WIDTH  coefficient value, signed QX.FRAC
- cfg_commit_i  in  1  request shadow→active copy
- commit_pend_o  out  1  commit requested, not yet applied
- flush_i  in  1  clear x/y history at next idle

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - x_ready_o=1.
  - A pending commit or flush is applied here, before any accept. The commit copies shadow→active and clears history. The flush clears history only. While either is pending, x_ready_o=0 for that one cycle.
  - On x_valid_i&x_ready_o: latch x, preload acc with 2^(FRAC-1) (round constant), step=0, go to MAC.
- MAC: five cycles, step 0..4, one product per cycle:
  - step 0: acc += b0·x
  - step 1: acc += b1·x1
  - step 2: acc += b2·x2
  - step 3: acc −= a1·y1
  - step 4: acc −= a2·y2
  - After step 4, go to DONE.
- DONE:
  - y = acc >>> FRAC (arithmetic), saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. ovf_o=1 if clamped.
  - Register y_out_o and pulse y_valid_o.
  - Shift history: x2←x1, x1←x, y2←y1, y1←y (saturated value).
  - Go to IDLE.
- Width rules:
  - Product width is 2·WIDTH.
  - acc is 2·WIDTH+3 bits signed and never wraps.
  - History registers are WIDTH bits.
- Configuration:
  - cfg_we_i writes the shadow bank in any state.
  - cfg_commit_i sets commit_pend_o, which stays high until the copy occurs in IDLE.
  - A commit received during MAC/DONE never affects the in-flight sample.
- Simultaneous events: cfg_commit_i and flush_i together → one commit, which already clears history. A cfg write in the same cycle as the copy lands in shadow after the copy, so it is not committed.
- No back-pressure on the output; downstream must take y_valid_o when pulsed.

## Timing
- Reset values:
  - x_ready_o=1, y_out_o=0, y_valid_o=0, ovf_o=0, commit_pend_o=0.
  - History is 0; state is IDLE.
  - Active and shadow banks hold the defaults b0=16384, b1=−31163, b2=16384, a1=−30851, a2=16058.
- Sample accepted at edge k → MAC at edges k+1..k+5 → y_out_o/y_valid_o registered at edge k+6. y_valid_o is high for the single cycle after that edge.
- x_ready_o returns high at edge k+6. Maximum throughput is one sample per 7 cycles.
- Reset asserted mid-MAC: the in-flight sample is lost, no y_valid_o, and all state returns to reset values, including the coefficient banks.

## Structure
- Package notch_seq_pkg holds:
  - the state enum (IDLE, MAC, DONE) and the coefficient index enum;
  - the default coefficient constants;
  - localparam ACC_W = 2·WIDTH+3.
- Sub-module notch_mac: the signed multiplier plus accumulator, with clear/preload, add/sub select and a shared-operand mux input. The FSM and coefficient banks stay in the top.

## Test plan
- Reset defaults: after reset, read behaviour → x_ready_o=1, y_valid_o=0, y_out_o=0.
- Identity coefficients: commit b0=16384 with all others 0, then x=1000 → y=1000 on the pulse 6 edges after accept.
- Delay tap: commit b1=16384 with all others 0, then x=5, 7, 9 → y=0, 5, 7.
- Saturation: b0=32767, x=30000 → y=32767, ovf_o=1. Then x=−30000 → y=−32768, ovf_o=1.
- Back-pressure and commit mid-op: x_valid_i held high continuously → accepts spaced exactly 7 cycles. A commit during MAC leaves that sample on the old coefficients. commit_pend_o clears in the next IDLE, and the sample after it sees cleared history.
- Reset mid-MAC: assert reset_i at step 2 → no y_valid_o. After release, x=1000 with default coefficients → y equals a golden-model first-sample value (b0·x rounded, = 1000).
